// File: rtl/packet_struct_pkg.sv
// Shared packet definitions: Ethernet header layout and frame-size constants.
package packet_struct_pkg;

  localparam int ETH_HDR_BYTES       = 14;
  localparam int ETH_HDR_W           = ETH_HDR_BYTES * 8;
  localparam int ETH_MIN_FRAME_BYTES = 60;

  // Byte 0 of the header (first destination MAC byte) sits in the MSBs.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } eth_hdr;

endpackage

// File: rtl/eth_frame_assemble.sv
// Prepends a 14-byte Ethernet header to a beat-aligned payload stream.
// Optional ETH_ASM_MIN_PAD_EN zero-pads short frames up to 60 bytes.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif

module eth_frame_assemble
  import packet_struct_pkg::*;
#(
  parameter int DATA_W     = `MAC_INTERFACE_W,
  parameter int PADBYTES_W = `MAC_PADBYTES_W,
  parameter int SIZE_W     = `MTU_SIZE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  src_eth_asm_hdr_val,
  input  eth_hdr                src_eth_asm_eth_hdr,
  input  logic [SIZE_W-1:0]     src_eth_asm_data_size,
  output logic                  eth_asm_src_hdr_rdy,

  input  logic                  src_eth_asm_data_val,
  input  logic [DATA_W-1:0]     src_eth_asm_data,
  input  logic                  src_eth_asm_data_last,
  input  logic [PADBYTES_W-1:0] src_eth_asm_data_padbytes,
  output logic                  eth_asm_src_data_rdy,

  output logic                  eth_asm_dst_data_val,
  output logic [DATA_W-1:0]     eth_asm_dst_data,
  output logic                  eth_asm_dst_data_last,
  output logic [PADBYTES_W-1:0] eth_asm_dst_data_padbytes,
  output logic [SIZE_W-1:0]     eth_asm_dst_frame_size,
  input  logic                  dst_eth_asm_data_rdy
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam logic [PADBYTES_W-1:0] HDR_PAD   = PADBYTES_W'(ETH_HDR_BYTES);
  localparam logic [PADBYTES_W-1:0] FLUSH_PAD = PADBYTES_W'(DATA_BYTES - ETH_HDR_BYTES);
  localparam logic [SIZE_W-1:0]     HDR_SIZE  = SIZE_W'(ETH_HDR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_DATA,
    S_FLUSH,
    S_PAD
  } state_t;

  state_t                  state_reg, state_next;
  eth_hdr                  hdr_reg;
  logic [ETH_HDR_W-1:0]    carry_reg;
  logic [SIZE_W-1:0]       frame_size_reg;
  logic [PADBYTES_W-1:0]   last_pad_reg;
  logic                    out_en_reg;

  logic [DATA_W-1:0]       raw_data;
  logic [PADBYTES_W-1:0]   mask_cnt;
  logic                    accept_hdr;
  logic                    accept_data;
  logic [SIZE_W-1:0]       size_next;

  assign accept_hdr  = eth_asm_src_hdr_rdy & src_eth_asm_hdr_val;
  assign accept_data = eth_asm_src_data_rdy & src_eth_asm_data_val;
  assign eth_asm_dst_frame_size = frame_size_reg;

`ifdef ETH_ASM_MIN_PAD_EN
  localparam logic [SIZE_W-1:0] MIN_SIZE = SIZE_W'(ETH_MIN_FRAME_BYTES);
  logic [SIZE_W-1:0]     out_cnt_reg;
  logic [SIZE_W-1:0]     cnt_end;
  logic [SIZE_W-1:0]     size_raw;
  logic                  cnt_final;
  logic [PADBYTES_W-1:0] cnt_pad;

  // A beat is the frame's last once the emitted byte count covers frame_size.
  assign size_raw  = src_eth_asm_data_size + HDR_SIZE;
  assign size_next = (size_raw < MIN_SIZE) ? MIN_SIZE : size_raw;
  assign cnt_end   = out_cnt_reg + SIZE_W'(DATA_BYTES);
  assign cnt_final = (cnt_end >= frame_size_reg);
  assign cnt_pad   = PADBYTES_W'(cnt_end - frame_size_reg);
`else
  assign size_next = src_eth_asm_data_size + HDR_SIZE;
`endif

  always_comb begin
    state_next                = state_reg;
    eth_asm_src_hdr_rdy       = 1'b0;
    eth_asm_src_data_rdy      = 1'b0;
    eth_asm_dst_data_val      = 1'b0;
    eth_asm_dst_data_last     = 1'b0;
    eth_asm_dst_data_padbytes = '0;
    raw_data                  = '0;
    mask_cnt                  = '0;

    case (state_reg)
      S_IDLE: begin
        eth_asm_src_hdr_rdy = out_en_reg;
        if (accept_hdr)
          state_next = S_FIRST;
      end

      S_FIRST, S_DATA: begin
        eth_asm_src_data_rdy = dst_eth_asm_data_rdy;
        eth_asm_dst_data_val = src_eth_asm_data_val;
        raw_data = {(state_reg == S_FIRST) ? hdr_reg : carry_reg,
                    src_eth_asm_data[DATA_W-1:ETH_HDR_W]};
        // The last beat fits whole when its empty tail can absorb the carry.
        if (src_eth_asm_data_last && (src_eth_asm_data_padbytes >= HDR_PAD)) begin
          mask_cnt                  = src_eth_asm_data_padbytes - HDR_PAD;
          eth_asm_dst_data_last     = 1'b1;
          eth_asm_dst_data_padbytes = src_eth_asm_data_padbytes - HDR_PAD;
`ifdef ETH_ASM_MIN_PAD_EN
          eth_asm_dst_data_last     = cnt_final;
          eth_asm_dst_data_padbytes = cnt_final ? cnt_pad : '0;
`endif
        end
        if (accept_data) begin
          if (!src_eth_asm_data_last)
            state_next = S_DATA;
          else if (src_eth_asm_data_padbytes < HDR_PAD)
            state_next = S_FLUSH;
          else
            state_next = eth_asm_dst_data_last ? S_IDLE : S_PAD;
        end
      end

      S_FLUSH: begin
        eth_asm_dst_data_val      = 1'b1;
        raw_data                  = {carry_reg, {(DATA_W-ETH_HDR_W){1'b0}}};
        mask_cnt                  = last_pad_reg + FLUSH_PAD;
        eth_asm_dst_data_last     = 1'b1;
        eth_asm_dst_data_padbytes = last_pad_reg + FLUSH_PAD;
`ifdef ETH_ASM_MIN_PAD_EN
        eth_asm_dst_data_last     = cnt_final;
        eth_asm_dst_data_padbytes = cnt_final ? cnt_pad : '0;
`endif
        if (dst_eth_asm_data_rdy)
          state_next = eth_asm_dst_data_last ? S_IDLE : S_PAD;
      end

`ifdef ETH_ASM_MIN_PAD_EN
      S_PAD: begin
        eth_asm_dst_data_val      = 1'b1;
        eth_asm_dst_data_last     = cnt_final;
        eth_asm_dst_data_padbytes = cnt_final ? cnt_pad : '0;
        if (dst_eth_asm_data_rdy && cnt_final)
          state_next = S_IDLE;
      end
`endif

      default: state_next = S_IDLE;
    endcase
  end

  // Bytes past the valid tail of the beat are forced to zero.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_mask
    assign eth_asm_dst_data[DATA_W-1-8*gi -: 8] =
      ((int'(mask_cnt) + gi) < DATA_BYTES) ? raw_data[DATA_W-1-8*gi -: 8] : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      hdr_reg        <= '0;
      carry_reg      <= '0;
      frame_size_reg <= '0;
      last_pad_reg   <= '0;
      out_en_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      out_en_reg <= 1'b1;
      if (accept_hdr) begin
        hdr_reg        <= src_eth_asm_eth_hdr;
        frame_size_reg <= size_next;
      end
      if (accept_data) begin
        carry_reg <= src_eth_asm_data[ETH_HDR_W-1:0];
        if (src_eth_asm_data_last)
          last_pad_reg <= src_eth_asm_data_padbytes;
      end
    end
  end

`ifdef ETH_ASM_MIN_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_cnt_reg <= '0;
    else if (accept_hdr)
      out_cnt_reg <= '0;
    else if (eth_asm_dst_data_val && dst_eth_asm_data_rdy)
      out_cnt_reg <= out_cnt_reg + SIZE_W'(DATA_BYTES);
  end
`endif

endmodule

// File: tb/tb_eth_frame_assemble.sv
// Scoreboard bench for eth_frame_assemble: directed frames, stalls, overlap and reset.
module tb_eth_frame_assemble;
  localparam int DW = 256;
  localparam int PW = 5;
  localparam int SW = 16;
  localparam int DB = 32;
  localparam int HB = 14;

`ifdef ETH_ASM_MIN_PAD_EN
  localparam int FS10 = 60, NB10 = 2, LP10 = 4;
  localparam int FS40 = 60, LP40 = 4;
`else
  localparam int FS10 = 24, NB10 = 1, LP10 = 8;
  localparam int FS40 = 54, LP40 = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            hdr_val;
  logic [111:0]    hdr_vec;
  logic [SW-1:0]   data_size;
  logic            hdr_rdy;
  logic            src_val;
  logic [DW-1:0]   src_data;
  logic            src_last;
  logic [PW-1:0]   src_pad;
  logic            src_rdy;
  logic            dst_val;
  logic [DW-1:0]   dst_data;
  logic            dst_last;
  logic [PW-1:0]   dst_pad;
  logic [SW-1:0]   dst_fsize;
  logic            dst_rdy;

  eth_frame_assemble dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .src_eth_asm_hdr_val       (hdr_val),
    .src_eth_asm_eth_hdr       (hdr_vec),
    .src_eth_asm_data_size     (data_size),
    .eth_asm_src_hdr_rdy       (hdr_rdy),
    .src_eth_asm_data_val      (src_val),
    .src_eth_asm_data          (src_data),
    .src_eth_asm_data_last     (src_last),
    .src_eth_asm_data_padbytes (src_pad),
    .eth_asm_src_data_rdy      (src_rdy),
    .eth_asm_dst_data_val      (dst_val),
    .eth_asm_dst_data          (dst_data),
    .eth_asm_dst_data_last     (dst_last),
    .eth_asm_dst_data_padbytes (dst_pad),
    .eth_asm_dst_frame_size    (dst_fsize),
    .dst_eth_asm_data_rdy      (dst_rdy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [PW-1:0] pad;
    logic [SW-1:0] fsize;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stall_tok = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] hbyte(input int idx, input int k);
    return 8'(idx * 16 + k + 1);
  endfunction

  function automatic logic [7:0] pbyte(input int idx, input int j);
    return 8'(idx * 7 + j + 3);
  endfunction

  // Expected output: the frame bytes (header, payload, zero fill) cut into beats.
  task automatic offer_hdr(input int idx, input int len, input int fs, input int nb, input int lp);
    exp_t e;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < DB; i++) begin
        int k = b * DB + i;
        logic [7:0] v;
        if (k < HB)            v = hbyte(idx, k);
        else if (k < HB + len) v = pbyte(idx, k - HB);
        else                   v = 8'h00;
        e.data[DW-1-8*i -: 8] = v;
      end
      e.last  = (b == nb - 1);
      e.pad   = e.last ? PW'(lp) : '0;
      e.fsize = SW'(fs);
      exp_q.push_back(e);
    end
    for (int k = 0; k < HB; k++) hdr_vec[111-8*k -: 8] = hbyte(idx, k);
    data_size = SW'(len);
    hdr_val   = 1'b1;
  endtask

  task automatic wait_hdr();
    int t = 0;
    logic ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (hdr_rdy) ok = 1'b1;
      @(posedge clk); #1;
      t++;
      if (!ok && t > 200) begin
        check("hdr_timeout", 1'b1, 1'b0);
        ok = 1'b1;
      end
    end
    hdr_val = 1'b0;
  endtask

  task automatic send_data(input int idx, input int len, input int max_beats, input int stall_beat);
    int nb = (len + DB - 1) / DB;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      int t = 0;
      logic ok = 1'b0;
      for (int i = 0; i < DB; i++) begin
        int j = b * DB + i;
        src_data[DW-1-8*i -: 8] = (j < len) ? pbyte(idx, j) : 8'hA5;
      end
      src_last = (b == nb - 1);
      src_pad  = src_last ? PW'(nb * DB - len) : '0;
      src_val  = 1'b1;
      while (!ok) begin
        @(negedge clk);
        if (src_rdy) begin
          ok = 1'b1;
          if (b == stall_beat) stall_tok++;
        end
        @(posedge clk); #1;
        t++;
        if (!ok && t > 200) begin
          check("data_timeout", 1'b1, 1'b0);
          ok = 1'b1;
        end
      end
    end
    src_val  = 1'b0;
    src_last = 1'b0;
    src_pad  = '0;
  endtask

  // Sink: ready high except for a 3-cycle stall each time stall_tok advances.
  initial begin
    int seen = 0;
    int cnt  = 0;
    dst_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_tok != seen) begin
        seen = stall_tok;
        cnt  = 3;
      end
      if (cnt > 0) begin
        dst_rdy = 1'b0;
        cnt--;
      end else begin
        dst_rdy = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic          in_frame = 1'b0;
    logic          chk_hdr  = 1'b0;
    logic          have_prev = 1'b0;
    logic [DW-1:0] prev = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame  = 1'b0;
        chk_hdr   = 1'b0;
        have_prev = 1'b0;
      end else begin
        if (chk_hdr) check("hdr_rdy_after_last", hdr_rdy, 1'b1);
        chk_hdr = 1'b0;
        if (in_frame && hdr_val) check("hdr_blocked", hdr_rdy, 1'b0);
        if (dst_val && have_prev) check("stall_hold", dst_data, prev);
        if (dst_val && !dst_rdy) begin
          check("stall_src_rdy", src_rdy, 1'b0);
          prev = dst_data;
          have_prev = 1'b1;
        end else begin
          have_prev = 1'b0;
        end
        if (dst_val && dst_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", dst_data, e.data);
            check("beat_last", dst_last, e.last);
            check("beat_pad", dst_pad, e.pad);
            check("frame_size", dst_fsize, e.fsize);
            $display("[TB] beat data=%h last=%0d pad=%0d fsize=%0d", dst_data, dst_last, dst_pad, dst_fsize);
          end
          if (dst_last) begin
            in_frame = 1'b0;
            chk_hdr  = 1'b1;
          end
        end
        if (hdr_val && hdr_rdy) in_frame = 1'b1;
      end
    end
  end

  initial begin
    int t;
    hdr_val   = 1'b0;
    hdr_vec   = '0;
    data_size = '0;
    src_val   = 1'b0;
    src_data  = '0;
    src_last  = 1'b0;
    src_pad   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_rdy", hdr_rdy, 1'b0);
    check("rst_dst_val", dst_val, 1'b0);
    check("rst_src_rdy", src_rdy, 1'b0);
    check("rst_fsize", dst_fsize, '0);
    check("rst_data", dst_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    offer_hdr(1, 10, FS10, NB10, LP10);   wait_hdr(); send_data(1, 10, 99, -1);
    offer_hdr(2, 64, 78, 3, 18);          wait_hdr(); send_data(2, 64, 99, 0);
    offer_hdr(3, 50, 64, 2, 0);           wait_hdr(); send_data(3, 50, 99, -1);
    offer_hdr(4, 40, FS40, 2, LP40);      wait_hdr(); send_data(4, 40, 99, -1);

    // Next header offered while the current frame is still streaming.
    offer_hdr(5, 40, FS40, 2, LP40);      wait_hdr();
    offer_hdr(6, 10, FS10, NB10, LP10);
    send_data(5, 40, 99, -1);
    wait_hdr();                           send_data(6, 10, 99, -1);

    // Reset in the middle of a frame drops the remainder.
    offer_hdr(7, 64, 78, 3, 18);          wait_hdr(); send_data(7, 64, 1, -1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dst_val", dst_val, 1'b0);
    check("midrst_hdr_rdy", hdr_rdy, 1'b0);
    check("midrst_src_rdy", src_rdy, 1'b0);
    check("midrst_last", dst_last, 1'b0);
    check("midrst_fsize", dst_fsize, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    offer_hdr(8, 10, FS10, NB10, LP10);   wait_hdr(); send_data(8, 10, 99, -1);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
